// File: rtl/wm_embedder.sv
// ---------------------------------------------------------------------------
// wm_embedder
//   Streaming watermark embedder placed directly after the LFSR watermark
//   generator. Each accepted pixel has its 1 or 2 LSBs replaced by the
//   generator's wm_data, then leaves through a 1-deep registered output stage.
//   wm_advance steps the generator exactly once per embedded pixel.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-cycle frame start pulse (honoured in IDLE only)
//   wm_select             0: 1-LSB embed, 1: 2-LSB embed (latched at start)
//   wm_data[1:0]          current generator output
//   wm_advance            generator clock enable (= pix_in_valid & pix_in_ready)
//   pix_in/_valid/_ready  input pixel stream
//   pix_out/_valid/_ready output pixel stream, pix_out_last marks final pixel
//   busy                  high while in EMBED or DRAIN
//   done                  1-cycle pulse after the last pixel has left
//   state_dbg[1:0]        current FSM state
//   wm_checksum[15:0]     (WM_CHECKSUM_EN only) sum of embedded bits in frame
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the output stage holds pix_out
// stable while pix_out_valid is high and pix_out_ready is low.
//
// Configuration: define WM_CHECKSUM_EN to add the wm_checksum accumulator.
// ---------------------------------------------------------------------------
module wm_embedder #(
  parameter int PIX_W      = 8,
  parameter int NUM_PIXELS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wm_select,
  input  logic [1:0]       wm_data,
  output logic             wm_advance,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic             pix_out_last,
  output logic             busy,
  output logic             done,
`ifdef WM_CHECKSUM_EN
  output logic [15:0]      wm_checksum,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EMBED = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             mode;
  logic             accept;
  logic             take;
  logic [PIX_W-1:0] embedded;

  // The output slot frees up in the same cycle it is taken, so a new pixel
  // can be accepted every cycle while downstream keeps up.
  assign pix_in_ready = (state == S_EMBED) && (!pix_out_valid || pix_out_ready);
  assign accept       = pix_in_valid && pix_in_ready;
  assign take         = pix_out_valid && pix_out_ready;
  assign wm_advance   = accept;
  assign busy         = (state == S_EMBED) || (state == S_DRAIN);
  assign done         = (state == S_DONE);
  assign state_dbg    = state;

  assign embedded = mode ? {pix_in[PIX_W-1:2], wm_data}
                         : {pix_in[PIX_W-1:1], wm_data[0]};

`ifdef WM_CHECKSUM_EN
  // Number of watermark bits actually inserted into the current pixel.
  logic [1:0] ins_bits;
  assign ins_bits = mode ? ({1'b0, wm_data[1]} + {1'b0, wm_data[0]})
                         : {1'b0, wm_data[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wm_checksum <= '0;
    end else if (state == S_IDLE && start) begin
      wm_checksum <= '0;
    end else if (accept) begin
      wm_checksum <= wm_checksum + {14'd0, ins_bits};
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      count         <= '0;
      mode          <= 1'b0;
      pix_out       <= '0;
      pix_out_valid <= 1'b0;
      pix_out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_EMBED;
            count <= '0;
            mode  <= wm_select;
          end
        end
        S_EMBED: begin
          if (accept) begin
            pix_out       <= embedded;
            pix_out_valid <= 1'b1;
            count         <= count + 1'b1;
            if (count == LAST_IDX) begin
              pix_out_last <= 1'b1;
              state        <= S_DRAIN;
            end
          end else if (take) begin
            pix_out_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (take) begin
            pix_out_valid <= 1'b0;
            pix_out_last  <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
